// File: rtl/change_dispenser.sv
// Coin change dispenser: greedily pays out change_amt one coin per valid/ready handshake.
// Optional macro COIN50_EN adds the 50-dollar coin to the {10, 5, 1} set.
module change_dispenser #(
  parameter int unsigned AMT_W = 10,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [AMT_W-1:0] change_amt,
  input  logic             coin_ready,
  output logic             coin_valid,
  output logic [5:0]       coin_value,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] coin_count
);

  localparam int unsigned COIN_W = 6;

  typedef enum logic [1:0] {
    IDLE,
    DISPENSE,
    FINISH
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [AMT_W-1:0]      remaining;
  logic [AMT_W-1:0]      remaining_next;
  logic [CNT_W-1:0]      coin_count_next;
  logic [COIN_W-1:0]     denom;
  logic                  coin_valid_next;
  logic                  busy_next;
  logic                  done_next;

  // Largest enabled denomination not exceeding what is still owed.
  always_comb begin
    denom = COIN_W'(0);
    if (remaining >= AMT_W'(1))  denom = COIN_W'(1);
    if (remaining >= AMT_W'(5))  denom = COIN_W'(5);
    if (remaining >= AMT_W'(10)) denom = COIN_W'(10);
`ifdef COIN50_EN
    if (remaining >= AMT_W'(50)) denom = COIN_W'(50);
`endif
  end

  assign coin_value = (state == DISPENSE) ? denom : COIN_W'(0);

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_next      = state;
    remaining_next  = remaining;
    coin_count_next = coin_count;
    unique case (state)
      IDLE: begin
        if (start) begin
          remaining_next  = change_amt;
          coin_count_next = CNT_W'(0);
          state_next      = (change_amt != AMT_W'(0)) ? DISPENSE : FINISH;
        end
      end
      DISPENSE: begin
        if (coin_ready) begin
          remaining_next  = remaining - AMT_W'(denom);
          coin_count_next = coin_count + CNT_W'(1);
          if (remaining == AMT_W'(denom)) state_next = FINISH;
        end
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    coin_valid_next = (state_next == DISPENSE);
    busy_next       = (state_next != IDLE);
    done_next       = (state_next == FINISH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      remaining  <= AMT_W'(0);
      coin_count <= CNT_W'(0);
      coin_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      remaining  <= remaining_next;
      coin_count <= coin_count_next;
      coin_valid <= coin_valid_next;
      busy       <= busy_next;
      done       <= done_next;
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized bench for change_dispenser against a greedy change-making model.
// Honors COIN50_EN the same way the design does.
module tb_change_dispenser;

  localparam int unsigned AMT_W = 10;
  localparam int unsigned CNT_W = 8;

  logic             clk;
  logic             reset;
  logic             start;
  logic [AMT_W-1:0] change_amt;
  logic             coin_ready;
  logic             coin_valid;
  logic [5:0]       coin_value;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] coin_count;

  int n_checks = 0;
  int n_errors = 0;

  change_dispenser #(.AMT_W(AMT_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .change_amt (change_amt),
    .coin_ready (coin_ready),
    .coin_valid (coin_valid),
    .coin_value (coin_value),
    .busy       (busy),
    .done       (done),
    .coin_count (coin_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  // Minimum-coin payout: canonical coin systems are optimal under greedy division.
  function automatic void model_coins(input int amt, output int coins[$]);
    int denoms[$];
    int rest;
`ifdef COIN50_EN
    denoms = '{50, 10, 5, 1};
`else
    denoms = '{10, 5, 1};
`endif
    coins = {};
    rest = amt;
    foreach (denoms[i]) begin
      for (int k = 0; k < rest / denoms[i]; k++) coins.push_back(denoms[i]);
      rest = rest % denoms[i];
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation; stall forces ready low for the first cycles, extra_start pokes start while busy.
  task automatic run_op(input int amt, input int ready_pct, input int stall, input bit extra_start);
    int  q[$];
    int  n;
    int  cyc;
    bit  fin;
    model_coins(amt, q);
    n = q.size();
    start      = 1'b1;
    change_amt = AMT_W'(amt);
    coin_ready = 1'($urandom_range(1));
    tick();
    start = 1'b0;
    fin   = (n == 0);
    cyc   = 0;
    while (1) begin
      check("busy_in_op", int'(busy), 1);
      check("done_timing", int'(done), int'(fin));
      check("coin_valid", int'(coin_valid), int'(!fin));
      if (fin) break;
      check("coin_value", int'(coin_value), q[0]);
      if (extra_start) begin
        start      = 1'b1;
        change_amt = AMT_W'(5);
      end
      coin_ready = (cyc < stall) ? 1'b0 : 1'(int'($urandom_range(99)) < ready_pct);
      if (coin_ready) begin
        void'(q.pop_front());
        if (q.size() == 0) fin = 1'b1;
      end
      tick();
      start = 1'b0;
      cyc++;
      if (cyc > 5000) begin
        check("timeout", 0, 1);
        return;
      end
    end
    check("count_finish", int'(coin_count), n);
    coin_ready = 1'b1;
    tick();
    check("idle_busy", int'(busy), 0);
    check("idle_done", int'(done), 0);
    check("idle_valid", int'(coin_valid), 0);
    check("idle_value", int'(coin_value), 0);
    tick();
    check("count_hold", int'(coin_count), n);
    coin_ready = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    change_amt = '0;
    coin_ready = 1'b0;
    tick();
    tick();
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_valid", int'(coin_valid), 0);
    check("rst_value", int'(coin_value), 0);
    check("rst_count", int'(coin_count), 0);

    // Reset outranks a simultaneous start.
    start      = 1'b1;
    change_amt = AMT_W'(7);
    tick();
    check("rst_prio_busy", int'(busy), 0);
    reset = 1'b0;
    start = 1'b0;
    tick();

    run_op(35, 100, 0, 1'b0);
    run_op(67, 100, 0, 1'b0);
    run_op(0, 100, 0, 1'b0);
    run_op(15, 100, 3, 1'b0);
    run_op(25, 100, 0, 1'b1);
    run_op(1, 100, 0, 1'b0);
    run_op(1023, 100, 0, 1'b0);

    // Abort mid-operation.
    start      = 1'b1;
    change_amt = AMT_W'(20);
    coin_ready = 1'b1;
    tick();
    start = 1'b0;
    check("abort_first_coin", int'(coin_value), 10);
    tick();
    check("abort_count1", int'(coin_count), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_valid", int'(coin_valid), 0);
    check("abort_count", int'(coin_count), 0);
    check("abort_done", int'(done), 0);
    tick();
    check("abort_no_done", int'(done), 0);
    check("abort_still_idle", int'(busy), 0);
    run_op(5, 100, 0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      run_op(int'($urandom_range(1023)), int'($urandom_range(100, 30)),
             int'($urandom_range(2)), 1'($urandom_range(1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL have parameter AMT_W, default 10, width of the change amount; it SHALL match the seller's money width.
REQ-002 SHALL have parameter CNT_W, default 8, width of the coin counter.
REQ-003 SHALL have port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to dispense the amount on change_amt.
REQ-006 SHALL have port change_amt  input  AMT_W  change to return in dollars, sampled only when start is accepted.
REQ-007 SHALL have port coin_ready  input  1  coin hopper accepts the presented coin this cycle.
REQ-008 SHALL have port coin_valid  output  1  a coin is presented on coin_value.
REQ-009 SHALL have port coin_value  output  6  denomination presented: 50, 10, 5 or 1, otherwise 0.
REQ-010 SHALL have port busy  output  1  a dispense operation is in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse when an operation completes.
REQ-012 SHALL have port coin_count  output  CNT_W  number of coins handed over in the current or last operation.

Function
REQ-013 SHALL implement the FSM states IDLE, DISPENSE and FINISH.
REQ-014 In IDLE, start=1 SHALL be accepted: remaining<=change_amt, coin_count<=0; the next state SHALL be DISPENSE if change_amt!=0, otherwise FINISH.
REQ-015 In DISPENSE, coin_valid SHALL be 1 and coin_value SHALL be the largest enabled denomination <= remaining.
REQ-016 coin_value SHALL be combinational from remaining.
REQ-017 coin_valid and coin_value SHALL stay stable until coin_ready=1 (valid/ready handshake).
REQ-018 On a handshake (coin_valid & coin_ready), remaining SHALL become remaining - coin_value and coin_count SHALL increment.
REQ-019 If the handshake takes remaining to 0, the next state SHALL be FINISH; otherwise the FSM SHALL stay in DISPENSE.
REQ-020 Coin latency: with coin_ready held at 1, the first coin SHALL appear in the cycle after start is accepted and one coin SHALL be handed over per cycle.
REQ-021 In FINISH, done SHALL be 1 for exactly one cycle, then the FSM SHALL go to IDLE; coin_count SHALL hold its value until the next accepted start.
REQ-022 busy SHALL be 1 in DISPENSE and FINISH and 0 in IDLE.
REQ-023 start while busy=1 SHALL be ignored: no queuing and no effect on remaining.
REQ-024 coin_ready while coin_valid=0 SHALL have no effect.
REQ-025 Arithmetic SHALL be unsigned with AMT_W bits; remaining SHALL never underflow, because the coin is always <= remaining.
REQ-026 The worst-case count (1023 dollars) SHALL fit in CNT_W=8 in both configurations.
REQ-027 Coins handed over SHALL always sum exactly to change_amt, using the minimum count for the enabled denominations.

Reset
REQ-028 reset=1 at a clock edge SHALL set: state=IDLE, remaining=0, coin_count=0, coin_valid=0, coin_value=0, busy=0, done=0.
REQ-029 reset SHALL take priority over start and over any handshake in the same cycle.
REQ-030 Reset mid-operation SHALL abort without a done pulse; coins already handed over SHALL not be re-issued.

Configuration
REQ-031 The macro COIN50_EN SHALL control the 50-dollar coin.
REQ-032 With COIN50_EN defined, denominations SHALL be {50, 10, 5, 1}.
REQ-033 Without COIN50_EN, denominations SHALL be {10, 5, 1} and coin_value SHALL never be 50.

Verification
REQ-034 No macro, start with change_amt=35, coin_ready=1 -> coins 10,10,10,5 on consecutive cycles; done one cycle after the 4th coin; coin_count=4.
REQ-035 COIN50_EN, change_amt=67 -> coins 50,10,5,1,1; coin_count=5; done pulses once.
REQ-036 change_amt=0 -> no coin_valid; done one cycle after start; coin_count=0.
REQ-037 change_amt=15, coin_ready low for 3 cycles, then high -> coin_value=10 held stable for all 3 stall cycles, then 10,5; done follows.
REQ-038 change_amt=25, a second start (change_amt=5) during DISPENSE -> the second start is ignored; exactly 10,10,5 issued.
REQ-039 change_amt=20, reset asserted after the first coin -> the next cycle has busy=0, coin_valid=0, coin_count=0 and no done; a fresh start of 5 then yields a single coin of 5.
